// File: rtl/floo_link_buffer.sv
// floo_link_buffer
//
// Elastic register-cut buffer for one direction of an inter-tile link.
// Every output (ready_o, valid_o, data_o) is driven from flops, so no
// combinational path crosses the tile boundary in either direction.
// The buffer also keeps saturating statistics counters for link bring-up:
// one for delivered flits and one for back-pressure cycles.
//
// Ports
//   clk_i        link clock; all state updates on the rising edge
//   rst_i        asynchronous active-high reset; discards all stored flits
//   valid_i      upstream flit valid
//   ready_o      buffer can accept a flit (registered)
//   data_i       upstream flit
//   valid_o      downstream flit valid (registered, equals fill != 0)
//   ready_i      downstream accepts the flit
//   data_o       head-of-buffer flit (read from storage at the read pointer)
//   clear_i      synchronous clear of both statistics counters
//   fill_o       current occupancy
//   flit_cnt_o   flits delivered downstream, saturating
//   stall_cnt_o  cycles with valid_o=1 and ready_i=0, saturating
//   idle_o       buffer empty and no flit offered upstream
module floo_link_buffer #(
    parameter int unsigned FlitWidth = 64,
    parameter int unsigned Depth     = 2,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [FlitWidth-1:0]       data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [FlitWidth-1:0]       data_o,
    input  logic                       clear_i,
    output logic [$clog2(Depth+1)-1:0] fill_o,
    output logic [CntWidth-1:0]        flit_cnt_o,
    output logic [CntWidth-1:0]        stall_cnt_o,
    output logic                       idle_o
);

    localparam int unsigned PtrWidth  = $clog2(Depth);
    localparam int unsigned FillWidth = $clog2(Depth + 1);

    localparam logic [PtrWidth-1:0]  LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [FillWidth-1:0] FullFill = FillWidth'(Depth);
    localparam logic [CntWidth-1:0]  CntMax   = '1;

    logic [FlitWidth-1:0] mem_reg [Depth];
    logic [PtrWidth-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PtrWidth-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [FillWidth-1:0] fill_reg, fill_next;
    logic                 ready_reg, ready_next;
    logic [CntWidth-1:0]  flit_cnt_reg, flit_cnt_next;
    logic [CntWidth-1:0]  stall_cnt_reg, stall_cnt_next;

    logic push;
    logic pop;
    logic stall;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    // ready_reg comes from the previous edge, so a pop in a full cycle
    // cannot free a slot for a same-cycle push: this keeps ready_o
    // independent of ready_i.
    assign push  = valid_i && ready_reg;
    assign pop   = (fill_reg != '0) && ready_i;
    assign stall = (fill_reg != '0) && !ready_i;

    always_comb begin
        fill_next   = fill_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push && !pop) begin
            fill_next = fill_reg + FillWidth'(1);
        end else if (pop && !push) begin
            fill_next = fill_reg - FillWidth'(1);
        end
        if (push) begin
            wr_ptr_next = next_ptr(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = next_ptr(rd_ptr_reg);
        end
        ready_next = (fill_next < FullFill);
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_comb begin
        flit_cnt_next  = flit_cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        if (clear_i) begin
            flit_cnt_next  = '0;
            stall_cnt_next = '0;
        end else begin
            if (pop && (flit_cnt_reg != CntMax)) begin
                flit_cnt_next = flit_cnt_reg + CntWidth'(1);
            end
            if (stall && (stall_cnt_reg != CntMax)) begin
                stall_cnt_next = stall_cnt_reg + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            fill_reg      <= '0;
            ready_reg     <= 1'b0;
            flit_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            fill_reg      <= fill_next;
            ready_reg     <= ready_next;
            flit_cnt_reg  <= flit_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // Storage is cleared on reset so data_o reads zero until the first push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            mem_reg[wr_ptr_reg] <= data_i;
        end
    end

    assign ready_o     = ready_reg;
    assign valid_o     = (fill_reg != '0);
    assign data_o      = mem_reg[rd_ptr_reg];
    assign fill_o      = fill_reg;
    assign flit_cnt_o  = flit_cnt_reg;
    assign stall_cnt_o = stall_cnt_reg;
    assign idle_o      = (fill_reg == '0) && !valid_i;

endmodule

// File: tb/tb_floo_link_buffer.sv
// tb_floo_link_buffer
//
// Drives two buffers from one shared upstream/downstream stimulus:
//   dut_a: Depth=2, CntWidth=32 (streaming, back-pressure, full+pop, reset)
//   dut_b: Depth=3, CntWidth=4  (pointer wrap, saturation, clear priority)
// Each buffer has a queue-based model; every cycle all outputs are
// compared against it, plus literal expectations at key points.
module tb_floo_link_buffer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_i;
    logic        clear_i;
    logic [63:0] data_i;

    logic        ready_o_a, valid_o_a, idle_o_a;
    logic [63:0] data_o_a;
    logic [1:0]  fill_o_a;
    logic [31:0] flit_cnt_a, stall_cnt_a;

    logic        ready_o_b, valid_o_b, idle_o_b;
    logic [63:0] data_o_b;
    logic [1:0]  fill_o_b;
    logic [3:0]  flit_cnt_b, stall_cnt_b;

    always #5 clk = ~clk;

    floo_link_buffer #(.FlitWidth(64), .Depth(2), .CntWidth(32)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o_a),
        .data_i(data_i), .valid_o(valid_o_a), .ready_i(ready_i), .data_o(data_o_a),
        .clear_i(clear_i), .fill_o(fill_o_a), .flit_cnt_o(flit_cnt_a),
        .stall_cnt_o(stall_cnt_a), .idle_o(idle_o_a)
    );

    floo_link_buffer #(.FlitWidth(64), .Depth(3), .CntWidth(4)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o_b),
        .data_i(data_i), .valid_o(valid_o_b), .ready_i(ready_i), .data_o(data_o_b),
        .clear_i(clear_i), .fill_o(fill_o_b), .flit_cnt_o(flit_cnt_b),
        .stall_cnt_o(stall_cnt_b), .idle_o(idle_o_b)
    );

    localparam longint unsigned MaxA = 64'hFFFF_FFFF;
    localparam longint unsigned MaxB = 64'hF;

    int n_vec = 0;
    int n_err = 0;

    // Models: queue contents, upstream-ready, counters, "storage still zero".
    logic [63:0]     qa[$];
    logic [63:0]     qb[$];
    bit              rdy_a, rdy_b, zero_a, zero_b;
    longint unsigned fc_a, sc_a, fc_b, sc_b;
    bit              push_a, push_b;
    logic [63:0]     rx_a[$];
    logic [63:0]     rx_b[$];
    int              max_fill_b = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_models();
        qa.delete();
        qb.delete();
        rdy_a  = 1'b0;
        rdy_b  = 1'b0;
        zero_a = 1'b1;
        zero_b = 1'b1;
        fc_a = 0; sc_a = 0; fc_b = 0; sc_b = 0;
    endtask

    task automatic check();
        cmp("a.ready", 64'(ready_o_a), 64'(rdy_a));
        cmp("a.valid", 64'(valid_o_a), 64'(qa.size() != 0));
        cmp("a.fill",  64'(fill_o_a),  64'(qa.size()));
        cmp("a.flit",  64'(flit_cnt_a), fc_a);
        cmp("a.stall", 64'(stall_cnt_a), sc_a);
        cmp("a.idle",  64'(idle_o_a),  64'(qa.size() == 0 && !valid_i));
        if (qa.size() != 0)  cmp("a.data", data_o_a, qa[0]);
        else if (zero_a)     cmp("a.data0", data_o_a, 64'h0);
        cmp("b.ready", 64'(ready_o_b), 64'(rdy_b));
        cmp("b.valid", 64'(valid_o_b), 64'(qb.size() != 0));
        cmp("b.fill",  64'(fill_o_b),  64'(qb.size()));
        cmp("b.flit",  64'(flit_cnt_b), fc_b);
        cmp("b.stall", 64'(stall_cnt_b), sc_b);
        cmp("b.idle",  64'(idle_o_b),  64'(qb.size() == 0 && !valid_i));
        if (qb.size() != 0)  cmp("b.data", data_o_b, qb[0]);
        else if (zero_b)     cmp("b.data0", data_o_b, 64'h0);
    endtask

    // One clock cycle: evaluate the handshake rules on the current inputs,
    // advance the models across the edge, then compare 1 time unit later.
    task automatic tick();
        bit pa, pb, opa, opb, sa, sb;
        pa  = valid_i && rdy_a;
        pb  = valid_i && rdy_b;
        opa = (qa.size() != 0) && ready_i;
        opb = (qb.size() != 0) && ready_i;
        sa  = (qa.size() != 0) && !ready_i;
        sb  = (qb.size() != 0) && !ready_i;
        if (valid_o_a && ready_i) rx_a.push_back(data_o_a);
        if (valid_o_b && ready_i) rx_b.push_back(data_o_b);
        @(posedge clk);
        if (rst_i) begin
            reset_models();
            push_a = 1'b0;
            push_b = 1'b0;
        end else begin
            fc_a = clear_i ? 0 : ((opa && fc_a != MaxA) ? fc_a + 1 : fc_a);
            sc_a = clear_i ? 0 : ((sa && sc_a != MaxA) ? sc_a + 1 : sc_a);
            fc_b = clear_i ? 0 : ((opb && fc_b != MaxB) ? fc_b + 1 : fc_b);
            sc_b = clear_i ? 0 : ((sb && sc_b != MaxB) ? sc_b + 1 : sc_b);
            if (opa) void'(qa.pop_front());
            if (opb) void'(qb.pop_front());
            if (pa) begin qa.push_back(data_i); zero_a = 1'b0; end
            if (pb) begin qb.push_back(data_i); zero_b = 1'b0; end
            rdy_a  = qa.size() < 2;
            rdy_b  = qb.size() < 3;
            push_a = pa;
            push_b = pb;
        end
        #1;
        check();
        if (int'(fill_o_b) > max_fill_b) max_fill_b = int'(fill_o_b);
    endtask

    task automatic drain(input int n);
        valid_i = 1'b0;
        ready_i = 1'b1;
        clear_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int k;
        int cyc;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; clear_i = 1'b0; data_i = '0;
        reset_models();
        push_a = 1'b0; push_b = 1'b0;

        // Reset state
        #3;
        check();
        cmp("rst.ready_a", 64'(ready_o_a), 64'h0);
        cmp("rst.data_a",  data_o_a, 64'h0);
        tick();
        rst_i = 1'b0;
        tick();
        cmp("release.ready_a", 64'(ready_o_a), 64'h1);

        // Streaming 0x1..0x10 with ready_i=1
        rx_a.delete();
        for (int i = 1; i <= 16; i++) begin
            valid_i = 1'b1; data_i = 64'(i); ready_i = 1'b1;
            tick();
            if (i == 1) begin
                cmp("stream.first_valid", 64'(valid_o_a), 64'h1);
                cmp("stream.first_data",  data_o_a, 64'h1);
            end
        end
        drain(3);
        cmp("stream.count", 64'(rx_a.size()), 64'd16);
        for (int j = 0; j < rx_a.size(); j++) cmp("stream.order", rx_a[j], 64'(j + 1));
        cmp("stream.flit_cnt", 64'(flit_cnt_a), 64'd16);
        cmp("stream.stall_cnt", 64'(stall_cnt_a), 64'd0);
        cmp("stream.sat_b", 64'(flit_cnt_b), 64'd15);

        // Back-pressure for 5 cycles, then full + simultaneous pop
        rx_a.delete();
        k = 0;
        for (int c = 0; c < 25; c++) begin
            ready_i = !(c >= 3 && c <= 7);
            valid_i = (k < 12);
            data_i  = 64'h100 + 64'(k);
            tick();
            if (push_a) k++;
            if (c == 7) begin
                cmp("bp.fill", 64'(fill_o_a), 64'd2);
                cmp("bp.ready", 64'(ready_o_a), 64'd0);
                cmp("bp.stall_cnt", 64'(stall_cnt_a), 64'd5);
            end
            if (c == 8) begin
                cmp("full_pop.fill", 64'(fill_o_a), 64'd1);
                cmp("full_pop.ready", 64'(ready_o_a), 64'd1);
            end
            if (c == 9) cmp("full_pop.next_push_fill", 64'(fill_o_a), 64'd1);
        end
        drain(2);
        cmp("bp.count", 64'(rx_a.size()), 64'd12);
        for (int j = 0; j < rx_a.size(); j++) cmp("bp.order", rx_a[j], 64'h100 + 64'(j));

        // Pointer wrap-around on the Depth=3 buffer with random handshakes
        rx_b.delete();
        k = 0;
        cyc = 0;
        while (k < 1000 && cyc < 20000) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            data_i  = 64'h2000 + 64'(k);
            tick();
            if (push_b) k++;
            cyc++;
        end
        if (k < 1000) cmp("wrap.timeout", 64'(k), 64'd1000);
        drain(5);
        cmp("wrap.count", 64'(rx_b.size()), 64'd1000);
        for (int j = 0; j < rx_b.size(); j++) cmp("wrap.order", rx_b[j], 64'h2000 + 64'(j));
        cmp("wrap.max_fill", 64'(max_fill_b <= 3), 64'd1);

        // Saturation and clear priority
        cmp("sat.flit_b", 64'(flit_cnt_b), 64'd15);
        valid_i = 1'b1; ready_i = 1'b0; data_i = 64'h500; tick();
        data_i = 64'h501; tick();
        cmp("clr.pre_fill_b", 64'(fill_o_b), 64'd2);
        data_i = 64'h502; ready_i = 1'b1; clear_i = 1'b1; tick();
        cmp("clr.flit_b", 64'(flit_cnt_b), 64'd0);
        cmp("clr.fill_b", 64'(fill_o_b), 64'd2);
        cmp("clr.flit_a", 64'(flit_cnt_a), 64'd0);
        valid_i = 1'b0; ready_i = 1'b0; clear_i = 1'b0; tick();
        cmp("clr.stall_inc_b", 64'(stall_cnt_b), 64'd1);
        clear_i = 1'b1; tick();
        cmp("clr.stall_prio_b", 64'(stall_cnt_b), 64'd0);
        drain(4);

        // Mid-stream asynchronous reset with fill=2
        valid_i = 1'b1; ready_i = 1'b0; data_i = 64'h600; tick();
        data_i = 64'h601; tick();
        cmp("mrst.pre_fill", 64'(fill_o_a), 64'd2);
        #2;
        rst_i = 1'b1;
        #1;
        cmp("mrst.valid", 64'(valid_o_a), 64'd0);
        cmp("mrst.ready", 64'(ready_o_a), 64'd0);
        cmp("mrst.fill",  64'(fill_o_a), 64'd0);
        reset_models();
        check();
        valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        valid_i = 1'b1; ready_i = 1'b1; data_i = 64'h700; tick();
        cmp("mrst.first_valid", 64'(valid_o_a), 64'd1);
        cmp("mrst.first_data", data_o_a, 64'h700);
        data_i = 64'h701; tick();
        cmp("mrst.second_data", data_o_a, 64'h701);
        drain(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/floo_link_buffer.md
# floo_link_buffer

Elastic, register-cut buffer for one direction of a FlooNoC inter-tile link. It sits between a tile's router output (e.g. the east request link) and the neighbouring tile's router input. It breaks every combinational path on valid, ready and data so that tile-to-tile wires close timing at the physical tile boundary. It also counts delivered flits and back-pressure cycles for link bring-up and performance debug.

## Interface
- FlitWidth, 64, width of the payload carried per handshake (the packed link flit).
- Depth, 2, number of flit storage entries; legal range 2..16; Depth=2 gives full throughput.
- CntWidth, 32, width of each statistics counter.

- clk_i  in  1  link clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  upstream flit valid.
- ready_o  out  1  buffer can accept a flit; registered.
- data_i  in  FlitWidth  upstream flit.
- valid_o  out  1  downstream flit valid; registered.
- ready_i  in  1  downstream accepts the flit.
- data_o  out  FlitWidth  head-of-buffer flit; registered storage output.
- clear_i  in  1  synchronous clear of both statistics counters.
- fill_o  out  $clog2(Depth+1)  current occupancy.
- flit_cnt_o  out  CntWidth  flits delivered downstream; saturating.
- stall_cnt_o  out  CntWidth  cycles with valid_o=1 and ready_i=0; saturating.
- idle_o  out  1  fill_o==0 and valid_i==0.

## Operation
- FIFO of Depth entries, written through a write pointer and read through a read pointer, each wrapping modulo Depth. Flit order is strictly preserved.
- Push occurs when valid_i && ready_o. Pop occurs when valid_o && ready_i.
- ready_o is a flop. Its next value is (fill_next < Depth). It depends on no input in the same cycle.
- valid_o equals (fill != 0) and is driven from state only. data_o is the entry at the read pointer.
- When the buffer is full (fill==Depth), ready_o=0, so a same-cycle pop does not allow a push. The entry freed by the pop becomes writable in the next cycle.
- Simultaneous push and pop: fill is unchanged and both pointers advance.
- Upstream protocol: data_i must be held stable while valid_i=1 and ready_o=0. The same rule applies downstream for data_o.
- Once valid_o is asserted, it stays asserted until a pop occurs, because the buffer never withdraws a flit.
- flit_cnt_o increments by 1 on each pop and holds at all-ones once saturated.
- stall_cnt_o increments by 1 on each cycle with valid_o && !ready_i and holds at all-ones once saturated.
- clear_i=1 forces both counters to 0 on the next edge; clear takes priority over a same-cycle increment. clear_i does not affect stored flits, pointers or fill.
- idle_o is combinational from fill and valid_i.

## Timing
- Reset values (applied asynchronously while rst_i=1): ready_o=0, valid_o=0, fill_o=0, pointers=0, storage=0 (so data_o=0), flit_cnt_o=0, stall_cnt_o=0.
- ready_o rises to 1 on the first clock edge after rst_i deasserts.
- Reset asserted mid-operation discards all stored flits immediately, with no drain. The upstream side is responsible for resending.
- Latency: a flit pushed at edge N is presented on valid_o/data_o after edge N, i.e. one cycle, when the buffer was empty. It is never presented combinationally in the same cycle.
- Throughput with ready_i held at 1: one flit per cycle for Depth≥2.
- When ready_i deasserts with Depth=2 and a stream in flight, at most 2 flits are absorbed before ready_o drops. No flit is lost or duplicated.
- fill_o and the counters reflect the state after the most recent edge.

## Test plan
- Reset release, streaming:
  - Stimulus: rst_i pulse, then valid_i=1 with data_i=0x1,0x2,...,0x10 on consecutive cycles, ready_i=1.
  - Required response: ready_o=1 one cycle after release; valid_o first high one cycle after the first push; data_o sequence 0x1..0x10 on consecutive cycles; flit_cnt_o=16; stall_cnt_o=0.
- Back-pressure, Depth=2:
  - Stimulus: a continuous stream with ready_i=0 for 5 cycles.
  - Required response: fill_o reaches 2 and ready_o=0; stall_cnt_o=5; after ready_i returns, no flit is lost or duplicated and order is preserved.
- Full plus simultaneous pop:
  - Stimulus: fill=Depth, then ready_i=1 and valid_i=1 in the same cycle.
  - Required response: pop only, fill becomes Depth-1; the push is accepted on the next cycle.
- Pointer wrap-around:
  - Stimulus: Depth=3 with random valid_i/ready_i over 1000 flits.
  - Required response: the output sequence equals the input sequence; fill_o never exceeds 3.
- Clear priority and saturation:
  - Stimulus: CntWidth=4, deliver 20 flits, then assert clear_i in the same cycle as a pop.
  - Required response: flit_cnt_o holds at 15 before the clear and reads 0 after it; fill_o is unchanged by the clear.
- Mid-stream reset:
  - Stimulus: assert rst_i asynchronously while fill=2.
  - Required response: valid_o, ready_o and fill_o go to 0 immediately, without waiting for a clock edge; after release, the first output flit is the first one pushed after reset.
